// File: rtl/div_restoring_if.sv
`default_nettype none
// ============================================================================
// Module   : div_restoring_if
// Brief    : Start/complete handshake and operand/result bundle for the divider.
// Revision : 1.0
// ============================================================================
interface div_restoring_if #(
    parameter int WIDTH_N = 32,
    parameter int WIDTH_D = 16
);
    logic               init;
    logic [WIDTH_N-1:0] op_N;
    logic [WIDTH_D-1:0] op_D;
    logic               busy;
    logic               done;
    logic [WIDTH_N-1:0] quotient;
    logic [WIDTH_D-1:0] remainder;
    logic               div_zero;

    modport master (
        output init, op_N, op_D,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  init, op_N, op_D,
        output busy, done, quotient, remainder, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/div_restoring.sv
`default_nettype none
// ============================================================================
// Module   : div_restoring
// Brief    : Sequential restoring shift-subtract divider, one quotient bit/clock.
// Revision : 1.0
// ============================================================================
module div_restoring #(
    parameter int WIDTH_N = 32,
    parameter int WIDTH_D = 16
) (
    input  wire             clk,
    input  wire             reset,
    div_restoring_if.slave  bus
);
    localparam int CW = $clog2(WIDTH_N);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH_N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_N-1:0]   work_q, work_d;
    logic [WIDTH_D:0]     rem_q, rem_d;
    logic [WIDTH_D-1:0]   divisor_q, divisor_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH_N-1:0]   quotient_q, quotient_d;
    logic [WIDTH_D-1:0]   remainder_q, remainder_d;
    logic                 div_zero_q, div_zero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH_D:0]     w_p;
    logic [WIDTH_D:0]     w_diff;
    logic                 w_qbit;
    logic [WIDTH_D:0]     w_rem_next;
    logic [WIDTH_N-1:0]   w_work_next;

    // rem < divisor is invariant, so p < 2*divisor and one trial subtract suffices
    always_comb begin
        w_p         = {rem_q[WIDTH_D-1:0], work_q[WIDTH_N-1]};
        w_diff      = w_p - {1'b0, divisor_q};
        w_qbit      = (w_p >= {1'b0, divisor_q});
        w_rem_next  = w_qbit ? w_diff : w_p;
        w_work_next = {work_q[WIDTH_N-2:0], w_qbit};
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.init) begin
                    if (bus.op_D != '0) begin
                        work_d     = bus.op_N;
                        divisor_d  = bus.op_D;
                        rem_d      = '0;
                        count_d    = '0;
                        div_zero_d = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = S_ITER;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = bus.op_N[WIDTH_D-1:0];
                        div_zero_d  = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_FINISH;
                    end
                end
            end
            S_ITER: begin
                rem_d   = w_rem_next;
                work_d  = w_work_next;
                count_d = count_q + 1'b1;
                if (count_q == C_LAST) begin
                    quotient_d  = w_work_next;
                    remainder_d = w_rem_next[WIDTH_D-1:0];
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: doc/div_restoring.md
Name: div_restoring

Overview:
- Sequential restoring shift-subtract divider; the inverse of the chronometer's shift-add multiplier.
- Converts running counts into display units, e.g. elapsed ms -> seconds, or seconds -> minutes plus remainder.
- Uses the same init/done start-complete handshake as the multiplier and sits beside it in the datapath.
- Produces one quotient bit per clock.

Parameters:
- WIDTH_N, 32, dividend and quotient width (matches the multiplier result width).
- WIDTH_D, 16, divisor and remainder width (matches the multiplier operand width).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- init  input  1  start request; sampled only in IDLE.
- op_N  input  WIDTH_N  dividend.
- op_D  input  WIDTH_D  divisor.
- busy  output  1  high while an operation is in progress (ITER state).
- done  output  1  one-cycle completion pulse.
- quotient  output  WIDTH_N  registered quotient.
- remainder  output  WIDTH_D  registered remainder.
- div_zero  output  1  divisor was zero; valid with done, held until the next accepted start.

Behaviour:
- Reset (reset=0, any state, including mid-operation):
  - state=IDLE; done=0, busy=0, quotient=0, remainder=0, div_zero=0.
  - Internal registers are cleared and any operation in flight is abandoned.
- States: IDLE, ITER, FINISH (2-bit encoding); any illegal encoding goes to IDLE.
- IDLE, init=0: hold state; outputs keep their last values.
- IDLE, init=1, op_D!=0 (accept edge E0):
  - Latch op_N into the working dividend/quotient shift register and op_D into the divisor register.
  - Clear the partial remainder (WIDTH_D+1 bits); clear bit counter (5 bits) to 0; clear div_zero.
  - state->ITER; busy=1.
- IDLE, init=1, op_D==0 (edge E0):
  - quotient<=all ones; remainder<=op_N[WIDTH_D-1:0]; div_zero<=1.
  - state->FINISH; done=1 in the following cycle.
- ITER, one quotient bit per edge:
  - p = {rem[WIDTH_D-1:0], work[WIDTH_N-1]}.
  - If p >= divisor: rem<=p-divisor and qbit=1; else rem<=p and qbit=0.
  - work <= {work[WIDTH_N-2:0], qbit}; count increments.
  - On the edge with count==WIDTH_N-1: quotient<=final work, remainder<=final rem[WIDTH_D-1:0], busy<=0, state->FINISH.
- FINISH: done=1 for exactly one cycle; next edge clears done and state->IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH_N (33 cycles after the accept edge with defaults); divide-by-zero: 1 cycle.
- init is ignored in ITER and FINISH; no queuing of requests.
- Operands are captured at E0; changes to op_N/op_D during ITER do not affect the result.
- Back-to-back: init held high continuously starts a new operation on the first IDLE edge after FINISH; quotient/remainder stay stable until the next completion overwrites them.
- Arithmetic is unsigned; the remainder is always < divisor; no overflow is possible (quotient width = dividend width).

Test Plan:
- op_N=100000, op_D=1000, init pulse -> after 33 cycles done=1 for one cycle, quotient=100, remainder=0, div_zero=0; busy high 32 cycles.
- op_N=59999, op_D=60 -> quotient=999, remainder=59; op_N=7, op_D=9 -> quotient=0, remainder=7.
- op_N=0xFFFFFFFF, op_D=0xFFFF -> quotient=0x00010001, remainder=0; op_N=0xFFFFFFFF, op_D=1 -> quotient=0xFFFFFFFF, remainder=0.
- op_N=1234, op_D=0 -> done the cycle after acceptance, quotient=0xFFFFFFFF, remainder=0x04D2, div_zero=1, busy never high.
- Drive reset=0 asynchronously at iteration 10 -> all outputs 0 immediately, no done pulse; after release, init with 100/7 -> quotient=14, remainder=2.
- Hold init=1 with op_N changed mid-ITER -> first result uses the operands captured at E0; a second operation starts the cycle after FINISH; init pulses during ITER are ignored.
